// File: rtl/legv8_inst_encoder.sv
// LEGv8 instruction encoder: builds 32-bit words from op/field requests and
// queues them with their byte address in a small FIFO behind valid/ready.
module legv8_inst_encoder #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [63:0] BASE_ADDR = 64'h0
) (
  input  logic        CLK,
  input  logic        resetl,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rn,
  input  logic [4:0]  in_rm,
  input  logic [1:0]  in_hw,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [63:0] out_addr,
  output logic        err_valid,
  output logic [1:0]  err_code,
  output logic [15:0] inst_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  localparam logic [1:0] ERR_ILLEGAL_OP = 2'b01;
  localparam logic [1:0] ERR_IMM_RANGE  = 2'b10;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] addr;
  } entry_t;

  // Combinational encoder and legality checks
  logic [31:0] enc_inst_c;
  logic        legal_op_c;
  logic        imm_ok_c;

  always_comb begin
    enc_inst_c = 32'h0;
    legal_op_c = 1'b1;
    imm_ok_c   = 1'b1;
    case (in_op)
      4'd0: enc_inst_c = {11'b10001011000, in_rm, 6'b000000, in_rn, in_rd};
      4'd1: enc_inst_c = {11'b11001011000, in_rm, 6'b000000, in_rn, in_rd};
      4'd2: enc_inst_c = {11'b10001010000, in_rm, 6'b000000, in_rn, in_rd};
      4'd3: enc_inst_c = {11'b10101010000, in_rm, 6'b000000, in_rn, in_rd};
      4'd4: begin
        enc_inst_c = {10'b1001000100, in_imm[11:0], in_rn, in_rd};
        imm_ok_c   = (in_imm[31:12] == 20'h0);
      end
      4'd5: begin
        enc_inst_c = {10'b1101000100, in_imm[11:0], in_rn, in_rd};
        imm_ok_c   = (in_imm[31:12] == 20'h0);
      end
      4'd6: begin
        enc_inst_c = {11'b11111000010, in_imm[8:0], 2'b00, in_rn, in_rd};
        imm_ok_c   = (in_imm[31:8] == {24{in_imm[8]}});
      end
      4'd7: begin
        enc_inst_c = {11'b11111000000, in_imm[8:0], 2'b00, in_rn, in_rd};
        imm_ok_c   = (in_imm[31:8] == {24{in_imm[8]}});
      end
      4'd8: begin
        enc_inst_c = {8'b10110100, in_imm[18:0], in_rd};
        imm_ok_c   = (in_imm[31:18] == {14{in_imm[18]}});
      end
      4'd9: begin
        enc_inst_c = {6'b000101, in_imm[25:0]};
        imm_ok_c   = (in_imm[31:25] == {7{in_imm[25]}});
      end
      4'd10: begin
        enc_inst_c = {9'b110100101, in_hw, in_imm[15:0], in_rd};
        imm_ok_c   = (in_imm[31:16] == 16'h0);
      end
      default: legal_op_c = 1'b0;
    endcase
  end

  entry_t      mem_q [DEPTH];
  entry_t      mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [63:0] addr_q, addr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic [63:0] out_addr_q, out_addr_d;
  logic        out_valid_q, out_valid_d;
  logic        err_valid_q, err_valid_d;
  logic [1:0]  err_code_q, err_code_d;

  logic full_c;
  logic accept_c;
  logic push_c;
  logic pop_c;

  assign full_c   = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
  assign accept_c = in_valid && !full_c;
  assign push_c   = accept_c && legal_op_c && imm_ok_c && !flush;
  assign pop_c    = out_valid_q && out_ready && !flush;

  // Next-state: FIFO pointers, address/count, head registers, error pulse
  always_comb begin
    mem_d       = mem_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    out_inst_d  = out_inst_q;
    out_addr_d  = out_addr_q;
    out_valid_d = out_valid_q;
    err_valid_d = 1'b0;
    err_code_d  = err_code_q;

    if (flush) begin
      wr_d        = '0;
      rd_d        = '0;
      addr_d      = BASE_ADDR;
      cnt_d       = 16'h0;
      out_valid_d = 1'b0;
    end else begin
      if (accept_c && !legal_op_c) begin
        err_valid_d = 1'b1;
        err_code_d  = ERR_ILLEGAL_OP;
      end else if (accept_c && !imm_ok_c) begin
        err_valid_d = 1'b1;
        err_code_d  = ERR_IMM_RANGE;
      end
      if (push_c) begin
        mem_d[wr_q[AW-1:0]] = '{inst: enc_inst_c, addr: addr_q};
        wr_d   = wr_q + PW'(1);
        addr_d = addr_q + 64'd4;
        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      end
      if (pop_c) rd_d = rd_q + PW'(1);
      out_valid_d = (wr_d != rd_d);
      // Head registers follow the new head; hold last word once empty
      if (out_valid_d) begin
        out_inst_d = mem_d[rd_d[AW-1:0]].inst;
        out_addr_d = mem_d[rd_d[AW-1:0]].addr;
      end
    end
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      addr_q      <= BASE_ADDR;
      cnt_q       <= 16'h0;
      out_inst_q  <= 32'h0;
      out_addr_q  <= BASE_ADDR;
      out_valid_q <= 1'b0;
      err_valid_q <= 1'b0;
      err_code_q  <= 2'b00;
    end else begin
      mem_q       <= mem_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      out_inst_q  <= out_inst_d;
      out_addr_q  <= out_addr_d;
      out_valid_q <= out_valid_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
    end
  end

  assign in_ready   = !full_c;
  assign out_valid  = out_valid_q;
  assign out_inst   = out_inst_q;
  assign out_addr   = out_addr_q;
  assign err_valid  = err_valid_q;
  assign err_code   = err_code_q;
  assign inst_count = cnt_q;

endmodule

// File: tb/tb_legv8_inst_encoder.sv
// Directed bench for legv8_inst_encoder with hand-computed instruction words.
module tb_legv8_inst_encoder;

  localparam int unsigned DEPTH = 4;

  logic        CLK = 1'b0;
  logic        resetl;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rd, in_rn, in_rm;
  logic [1:0]  in_hw;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [63:0] out_addr;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [15:0] inst_count;

  int tests_run    = 0;
  int tests_failed = 0;

  legv8_inst_encoder #(.DEPTH(DEPTH), .BASE_ADDR(64'h0)) dut (
    .CLK(CLK), .resetl(resetl), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_hw(in_hw), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_addr(out_addr),
    .err_valid(err_valid), .err_code(err_code), .inst_count(inst_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic req(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                     input logic [4:0] rm, input logic [1:0] hw, input logic [31:0] imm);
    in_valid = 1'b1;
    in_op    = op;
    in_rd    = rd;
    in_rn    = rn;
    in_rm    = rm;
    in_hw    = hw;
    in_imm   = imm;
  endtask

  logic [3:0]  s_op  [4] = '{4'd4, 4'd6, 4'd8, 4'd9};
  logic [4:0]  s_rd  [4] = '{5'd9, 5'd2, 5'd7, 5'd0};
  logic [4:0]  s_rn  [4] = '{5'd10, 5'd5, 5'd0, 5'd0};
  logic [31:0] s_imm [4] = '{32'd1, 32'hFFFF_FFF8, 32'd3, 32'hFFFF_FFFF};
  logic [31:0] s_exp [4] = '{32'h91000549, 32'hF85F80A2, 32'hB4000067, 32'h17FFFFFF};

  logic [3:0]  f_op  [5] = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd0};
  logic [4:0]  f_rd  [5] = '{5'd1, 5'd4, 5'd31, 5'd0, 5'd0};
  logic [4:0]  f_rn  [5] = '{5'd2, 5'd5, 5'd31, 5'd1, 5'd0};
  logic [4:0]  f_rm  [5] = '{5'd3, 5'd6, 5'd31, 5'd0, 5'd0};
  logic [31:0] f_imm [5] = '{32'd0, 32'd0, 32'd0, 32'd4095, 32'd0};
  logic [31:0] f_exp [5] = '{32'hCB030041, 32'h8A0600A4, 32'hAA1F03FF, 32'hD13FFC20, 32'h8B000000};

  initial begin
    resetl = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b0; in_op = '0; in_rd = '0; in_rn = '0; in_rm = '0; in_hw = '0; in_imm = '0;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_inst", 64'(out_inst), 64'd0);
    chk("rst_out_addr", out_addr, 64'd0);
    chk("rst_err_valid", 64'(err_valid), 64'd0);
    chk("rst_err_code", 64'(err_code), 64'd0);
    chk("rst_count", 64'(inst_count), 64'd0);
    @(negedge CLK);
    resetl = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Single ADD into empty FIFO with out_ready high: no bypass, 1-cycle latency
    out_ready = 1'b1;
    req(4'd0, 5'd3, 5'd1, 5'd2, 2'd0, 32'd0);
    chk("add_no_bypass", 64'(out_valid), 64'd0);
    tick();
    in_valid = 1'b0;
    chk("add_valid", 64'(out_valid), 64'd1);
    chk("add_inst", 64'(out_inst), 64'h8B020023);
    chk("add_addr", out_addr, 64'd0);
    chk("add_count", 64'(inst_count), 64'd1);
    tick();
    chk("add_popped", 64'(out_valid), 64'd0);
    chk("add_hold_inst", 64'(out_inst), 64'h8B020023);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush1_count", 64'(inst_count), 64'd0);

    // Back-to-back stream with out_ready=1
    for (int i = 0; i < 4; i++) begin
      req(s_op[i], s_rd[i], s_rn[i], 5'd0, 2'd0, s_imm[i]);
      tick();
      chk("stream_inst", 64'(out_inst), 64'(s_exp[i]));
      chk("stream_addr", out_addr, 64'(4 * i));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_empty", 64'(out_valid), 64'd0);
    chk("stream_count", 64'(inst_count), 64'd4);

    // Error paths
    out_ready = 1'b0;
    req(4'd4, 5'd1, 5'd1, 5'd0, 2'd0, 32'd4096);
    tick();
    in_valid = 1'b0;
    chk("addi_range_err", 64'(err_valid), 64'd1);
    chk("addi_range_code", 64'(err_code), 64'd2);
    chk("addi_range_nopush", 64'(out_valid), 64'd0);
    tick();
    chk("err_pulse_end", 64'(err_valid), 64'd0);
    chk("err_code_hold", 64'(err_code), 64'd2);
    req(4'd13, 5'd1, 5'd1, 5'd0, 2'd0, 32'hFFFF_0000);
    tick();
    chk("illegal_err", 64'(err_valid), 64'd1);
    chk("illegal_code", 64'(err_code), 64'd1);
    req(4'd6, 5'd1, 5'd1, 5'd0, 2'd0, 32'd256);
    tick();
    chk("ldur_range_code", 64'(err_code), 64'd2);
    chk("err_count", 64'(inst_count), 64'd4);

    // MOVZ after errors: address counter unchanged
    req(4'd10, 5'd1, 5'd0, 5'd0, 2'd1, 32'h0000_1234);
    tick();
    chk("movz_inst", 64'(out_inst), 64'hD2A24681);
    chk("movz_addr", out_addr, 64'd16);
    chk("movz_err_clr", 64'(err_valid), 64'd0);
    req(4'd7, 5'd4, 5'd6, 5'd0, 2'd0, 32'hFFFF_FF00);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("stur_inst", 64'(out_inst), 64'hF81000C4);
    chk("stur_addr", out_addr, 64'd20);
    tick();
    chk("drain_empty", 64'(out_valid), 64'd0);

    // Fill with out_ready=0
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req(f_op[i], f_rd[i], f_rn[i], f_rm[i], 2'd0, f_imm[i]);
      tick();
      chk("fill_head_inst", 64'(out_inst), 64'hCB030041);
      chk("fill_head_addr", out_addr, 64'd24);
      chk("fill_in_ready", 64'(in_ready), (i >= 3) ? 64'd0 : 64'd1);
    end
    chk("fill_count", 64'(inst_count), 64'd10);
    // Pop while full and valid still high: input stays blocked this edge
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pop_full_count", 64'(inst_count), 64'd10);
    chk("pop_in_ready", 64'(in_ready), 64'd1);
    chk("pop_head_inst", 64'(out_inst), 64'h8A0600A4);
    chk("pop_head_addr", out_addr, 64'd28);
    tick();
    in_valid = 1'b0;
    chk("push5_count", 64'(inst_count), 64'd11);
    chk("push5_full", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("three_left_inst", 64'(out_inst), 64'hAA1F03FF);
    chk("three_left_addr", out_addr, 64'd32);

    // Flush with a simultaneous push and pop request
    flush = 1'b1; out_ready = 1'b1;
    req(4'd0, 5'd5, 5'd5, 5'd5, 2'd0, 32'd0);
    tick();
    flush = 1'b0; out_ready = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_count", 64'(inst_count), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    req(4'd0, 5'd3, 5'd1, 5'd2, 2'd0, 32'd0);
    tick();
    chk("post_flush_addr", out_addr, 64'd0);
    chk("post_flush_inst", 64'(out_inst), 64'h8B020023);
    chk("post_flush_count", 64'(inst_count), 64'd1);

    // Pending error plus buffered word, then async reset between edges
    req(4'd15, 5'd0, 5'd0, 5'd0, 2'd0, 32'd0);
    tick();
    in_valid = 1'b0;
    chk("pre_rst_err", 64'(err_valid), 64'd1);
    #2;
    resetl = 1'b0;
    #1;
    chk("async_valid", 64'(out_valid), 64'd0);
    chk("async_inst", 64'(out_inst), 64'd0);
    chk("async_addr", out_addr, 64'd0);
    chk("async_err", 64'(err_valid), 64'd0);
    chk("async_code", 64'(err_code), 64'd0);
    chk("async_count", 64'(inst_count), 64'd0);
    #3;
    resetl = 1'b1;
    tick();
    chk("post_rst_ready", 64'(in_ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
